// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/div_unit_abs_neg.sv
// Conditional two's-complement negate (modulo 2^WIDTH); used for operand
// magnitudes and for restoring the result signs.
module div_unit_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/div_unit.sv
// Sequential signed restoring divider with MIPS DIV semantics: quotient to
// lo_out, remainder to hi_out, one-cycle done pulse, divide-by-zero flag.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_quo_q, sgn_quo_d;
  logic               sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               busy_d, done_d, dz_d;

  logic [WIDTH-1:0]   dvd_mag_c, dvs_mag_c, quo_fix_c, rem_fix_c;
  logic [WIDTH:0]     shift_c, trial_c;
  logic               dvs_zero_c;

  div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
    .val_i(dividend), .neg_i(dividend[WIDTH-1]), .val_o(dvd_mag_c)
  );
  div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
    .val_i(divisor), .neg_i(divisor[WIDTH-1]), .val_o(dvs_mag_c)
  );
  div_unit_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i(quo_q), .neg_i(sgn_quo_q), .val_o(quo_fix_c)
  );
  div_unit_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(rem_q), .neg_i(sgn_rem_q), .val_o(rem_fix_c)
  );

  assign dvs_zero_c = (divisor == '0);
  // Remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH+1 bits cannot overflow
  assign shift_c    = {rem_q, quo_q[WIDTH-1]};
  assign trial_c    = shift_c - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !dvs_zero_c) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_out;
    lo_d      = lo_out;
    dz_d      = div_zero;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d   = dvs_zero_c;
          done_d = dvs_zero_c;
          if (!dvs_zero_c) begin
            sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_rem_d = dividend[WIDTH-1];
            quo_d     = dvd_mag_c;
            dvs_d     = dvs_mag_c;
            rem_d     = '0;
            cnt_d     = '0;
          end
        end
      end
      S_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
        rem_d = trial_c[WIDTH] ? shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        lo_d   = quo_fix_c;
        hi_d   = rem_fix_c;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      hi_out    <= hi_d;
      lo_out    <= lo_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= dz_d;
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit divider implementing MIPS DIV semantics.
- Sits directly upstream of the HI/LO divide/multiply select muxes: lo_out drives DivLOout (quotient) and hi_out drives DivHIout (remainder).
- Started by the control FSM with a one-cycle pulse; reports completion with a one-cycle done pulse.
- Flags divide-by-zero so the control FSM can raise the exception path.

Parameters:
WIDTH, 32, operand/result width; RUN phase lasts WIDTH cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
dividend  input  WIDTH  A register value (rs), two's complement.
divisor  input  WIDTH  B register value (rt), two's complement.
hi_out  output  WIDTH  remainder; to DivHIout.
lo_out  output  WIDTH  quotient; to DivLOout.
busy  output  1  high while in RUN or FIX.
done  output  1  one-cycle completion pulse.
div_zero  output  1  divide-by-zero flag.

Behaviour:
- Reset: reset low clears, asynchronously, all state and outputs: state=IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, counter=0. Reset asserted mid-RUN aborts the operation. No done pulse is produced.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - div_zero<=0.
  - If divisor==0: div_zero<=1 and done<=1 for the next cycle only. State stays IDLE. hi_out and lo_out are unchanged.
  - Otherwise: latch sign_q = dividend[W-1]^divisor[W-1] and sign_r = dividend[W-1]. Load |dividend| into the quotient shift register, |divisor| into the divisor register, and 0 into the partial remainder (WIDTH+1 bits). Set counter=0 and go to RUN. busy=1 from the cycle after E0.
- RUN: one restoring iteration per edge.
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor. If trial is non-negative, rem<=trial and quo[0]<=1; else quo[0]<=0.
  - counter increments. After iteration WIDTH (edge E_WIDTH) go to FIX.
- FIX, edge E_WIDTH+1:
  - lo_out <= sign_q ? -quo : quo.
  - hi_out <= sign_r ? -rem[W-1:0] : rem[W-1:0].
  - done<=1 for exactly one cycle, busy<=0, go to IDLE.
  - Total latency: done is high in the cycle after E33 for WIDTH=32.
- Absolute values and negation are taken modulo 2^WIDTH. |0x80000000| therefore stays 0x80000000 and is treated as the unsigned magnitude 2^31.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. No flag is raised.
- start while busy is ignored; operands are not re-sampled. Operand changes during RUN have no effect.
- start in the same cycle done is high: accepted normally, since the state is IDLE.
- hi_out and lo_out hold their values until the next successful FIX or reset. div_zero holds until the next accepted start or reset.
- Remainder sign follows the dividend and quotient truncates toward zero. This matches MIPS DIV.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_RUN, S_FIX), the default WIDTH, and the counter width $clog2(WIDTH)+1.
- One natural sub-module: abs_neg (combinational conditional two's-complement negate). It is instantiated for the operand magnitudes and for the result sign fix.
- The FSM and datapath stay in div_unit.

Test Plan:
- 7 / 2: start pulse -> done exactly 34 cycles after the start edge (WIDTH=32); lo_out=0x00000003, hi_out=0x00000001, div_zero=0; busy high for 33 cycles.
- Signs: -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001; -7/-2 -> lo=0x00000003, hi=0xFFFFFFFF.
- Divide by zero: after a prior 100/7 (lo=14, hi=2), start 5/0 -> done and div_zero high the next cycle; lo=14 and hi=2 retained; busy never high; div_zero clears on the next accepted start.
- Extremes: 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. 0xFFFFFFFF/0x80000000 -> lo=0, hi=0xFFFFFFFF. 0/5 -> lo=0, hi=0.
- Start while busy: start 100/7, re-pulse start with 9/3 at cycle 10 -> single done at cycle 34 with lo=14, hi=2; no second done.
- Reset mid-op: start 100/7, drop reset at cycle 15 for 1 cycle -> all outputs 0 immediately, state IDLE, no done; a subsequent start 9/3 yields lo=3, hi=0.
